// File: rtl/iir_inverse.sv
// rtl/iir_inverse.sv - inverse of y[n] = A*y[n-1] + B*x[n]: recovers x[n] via two-cycle multiply and serial restoring divide.
// Define IIR_INV_SAT_EN to saturate out-of-range quotients instead of wrapping them.
module iir_inverse #(
    parameter logic signed [7:0] A  = 8'sd3,
    parameter logic signed [7:0] B  = -8'sd4,
    parameter int                YW = 26
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [YW-1:0] y_in,
    input  logic                 y_en,
    output logic                 ready,
    output logic                 drop,
    output logic signed [7:0]    x_out,
    output logic                 x_valid,
    output logic                 x_err
);
    localparam int DW    = YW + 9;
    localparam int PW    = YW + 8;
    localparam int LO    = YW / 2;
    localparam int CW    = $clog2(DW + 1);
    localparam int B_MAG = (B < 0) ? -int'(B) : int'(B);

    typedef enum logic [2:0] {IDLE, MUL1, MUL2, SUB, DIV, DONE} state_t;

    state_t               state, state_nxt;
    logic signed [YW-1:0] y_cap, y_prev;
    logic signed [PW-1:0] p_lo, prod;
    logic signed [PW-1:0] lo_pp, hi_pp;
    logic signed [DW-1:0] e;
    logic [DW-1:0]        e_abs;
    logic                 e_neg;
    logic [DW-1:0]        rem, quo, dvs;
    logic [CW-1:0]        cnt;
    logic                 accept;

    logic [DW:0]          trial;
    logic [DW-1:0]        diff, rem_step, quo_step;
    logic                 ge, neg, over, err;
    logic [7:0]           q_lo, x_wrap, x_fin;

    assign ready  = (state == IDLE || state == DONE) && !rst;
    assign accept = y_en && ready;

    // Product split into an unsigned low half and a signed high half, one per MUL cycle.
    assign lo_pp = PW'(A) * PW'($signed({1'b0, y_prev[LO-1:0]}));
    assign hi_pp = PW'(A) * PW'($signed(y_prev[YW-1:LO]));

    assign e     = DW'(y_cap) - DW'(prod);
    assign e_abs = e[DW-1] ? DW'(-e) : DW'(e);

    // One restoring step: shift the next dividend bit into the partial remainder.
    assign trial    = {rem, quo[DW-1]};
    assign ge       = trial >= {1'b0, dvs};
    assign diff     = trial[DW-1:0] - dvs;
    assign rem_step = ge ? diff : trial[DW-1:0];
    assign quo_step = {quo[DW-2:0], ge};

    assign neg    = e_neg ^ B[7];
    assign over   = neg ? (quo_step > DW'(128)) : (quo_step > DW'(127));
    assign err    = (rem_step != '0) || over;
    assign q_lo   = quo_step[7:0];
    assign x_wrap = neg ? 8'(-q_lo) : q_lo;
`ifdef IIR_INV_SAT_EN
    assign x_fin  = over ? (neg ? 8'h80 : 8'h7f) : x_wrap;
`else
    assign x_fin  = x_wrap;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = MUL1;
            MUL1:    state_nxt = MUL2;
            MUL2:    state_nxt = SUB;
            SUB:     state_nxt = DIV;
            DIV:     if (cnt == CW'(1)) state_nxt = DONE;
            DONE:    state_nxt = accept ? MUL1 : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            y_cap   <= '0;
            y_prev  <= '0;
            p_lo    <= '0;
            prod    <= '0;
            e_neg   <= 1'b0;
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            cnt     <= '0;
            x_out   <= '0;
            x_valid <= 1'b0;
            x_err   <= 1'b0;
            drop    <= 1'b0;
        end else begin
            state   <= state_nxt;
            x_valid <= 1'b0;
            drop    <= y_en && !ready;
            if (accept) y_cap <= y_in;
            case (state)
                MUL1: p_lo <= lo_pp;
                MUL2: prod <= (hi_pp <<< LO) + p_lo;
                SUB: begin
                    y_prev <= y_cap;
                    e_neg  <= e[DW-1];
                    rem    <= '0;
                    quo    <= e_abs;
                    dvs    <= DW'(B_MAG);
                    cnt    <= CW'(DW);
                end
                DIV: begin
                    rem <= rem_step;
                    quo <= quo_step;
                    cnt <= cnt - CW'(1);
                    // Last step: results land in the output registers as DONE begins.
                    if (cnt == CW'(1)) begin
                        x_out   <= x_fin;
                        x_err   <= err;
                        x_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
